// File: rtl/pmp_pkg.sv
// rtl/pmp_pkg.sv - PMP configuration types, CSR map constants and cfg legalisation
package pmp_pkg;

    typedef enum logic [1:0] {
        PMP_OFF   = 2'd0,
        PMP_TOR   = 2'd1,
        PMP_NA4   = 2'd2,
        PMP_NAPOT = 2'd3
    } pmp_mode_e;

    typedef enum logic [1:0] {
        ACC_READ  = 2'd0,
        ACC_WRITE = 2'd1,
        ACC_EXEC  = 2'd2
    } access_e;

    typedef struct packed {
        logic       l;
        logic [1:0] rsvd;
        pmp_mode_e  a;
        logic       x;
        logic       w;
        logic       r;
    } pmpcfg_t;

    localparam logic [11:0] CSR_PMPCFG_BASE  = 12'h3A0;
    localparam logic [11:0] CSR_PMPADDR_BASE = 12'h3B0;
    localparam logic [1:0]  PRIV_M           = 2'd3;

    // Reserved bits are forced to zero and the R=0/W=1 combination is illegal, so W drops.
    function automatic pmpcfg_t pmpcfg_legalize(input logic [7:0] raw);
        pmpcfg_t c;
        c      = pmpcfg_t'(raw);
        c.rsvd = 2'b00;
        if (!c.r && c.w) c.w = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/pmp_entry_match.sv
// rtl/pmp_entry_match.sv - combinational address match for one PMP entry in word space
module pmp_entry_match
    import pmp_pkg::*;
#(
    parameter int AW = 30
) (
    input  pmp_mode_e       mode,
    input  logic [AW-1:0]   lo,
    input  logic [AW-1:0]   hi,
    input  logic [AW-1:0]   a,
    input  logic [AW:0]     e,
    output logic            match,
    output logic            partial
);

    logic          start_in;
    logic          end_in;
    logic [AW-1:0] napot_low;

    // hi ^ (hi+1) sets the trailing-ones run plus one bit: exactly the don't-care bits of a NAPOT region.
    assign napot_low = hi ^ (hi + AW'(1));

    always_comb begin
        start_in = 1'b0;
        end_in   = 1'b0;
        case (mode)
            PMP_TOR: begin
                start_in = (a >= lo) && (a < hi);
                end_in   = (e >= {1'b0, lo}) && (e < {1'b0, hi});
            end
            PMP_NA4: begin
                start_in = (a == hi);
                end_in   = (e == {1'b0, hi});
            end
            PMP_NAPOT: begin
                start_in = ((a ^ hi) & ~napot_low) == '0;
                end_in   = !e[AW] && (((e[AW-1:0] ^ hi) & ~napot_low) == '0);
            end
            default: begin
                start_in = 1'b0;
                end_in   = 1'b0;
            end
        endcase
    end

    assign match   = start_in | end_in;
    assign partial = start_in ^ end_in;

endmodule

// File: rtl/pmp_unit.sv
// rtl/pmp_unit.sv - PMP CSR storage with lock rules and one-stage registered access check
module pmp_unit
    import pmp_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int PADDR_W     = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               csr_we,
    input  logic [11:0]        csr_addr,
    input  logic [31:0]        csr_wdata,
    output logic [31:0]        csr_rdata,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [PADDR_W-1:0] req_addr,
    input  logic [1:0]         req_size,
    input  logic [1:0]         req_type,
    input  logic [1:0]         req_priv,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_fault,
    output logic               rsp_hit,
    output logic [3:0]         rsp_entry
);

    localparam int AW = PADDR_W - 2;

    pmpcfg_t               cfg_q   [NUM_ENTRIES];
    logic [AW-1:0]         addr_q  [NUM_ENTRIES];
    logic [AW-1:0]         lo_w    [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] addr_lock;
    logic [NUM_ENTRIES-1:0] ent_match;
    logic [NUM_ENTRIES-1:0] ent_partial;

    logic [1:0]     size_off;
    logic [PADDR_W:0] end_byte;
    logic [AW-1:0]  word_a;
    logic [AW:0]    word_e;

    assign size_off = (req_size == 2'd0) ? 2'd0 : (req_size == 2'd1) ? 2'd1 : 2'd3;
    // One extra bit keeps an access running off the top of memory from wrapping into low addresses.
    assign end_byte = {1'b0, req_addr} + (PADDR_W+1)'(size_off);
    assign word_a   = req_addr[PADDR_W-1:2];
    assign word_e   = end_byte[PADDR_W:2];

    for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_entry
        if (i == 0) begin : g_first
            assign lo_w[i] = '0;
        end else begin : g_rest
            assign lo_w[i] = addr_q[i-1];
        end

        if (i + 1 < NUM_ENTRIES) begin : g_lock_next
            assign addr_lock[i] = cfg_q[i].l || (cfg_q[i+1].l && cfg_q[i+1].a == PMP_TOR);
        end else begin : g_lock_last
            assign addr_lock[i] = cfg_q[i].l;
        end

        pmp_entry_match #(.AW(AW)) u_match (
            .mode    (cfg_q[i].a),
            .lo      (lo_w[i]),
            .hi      (addr_q[i]),
            .a       (word_a),
            .e       (word_e),
            .match   (ent_match[i]),
            .partial (ent_partial[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                cfg_q[i]  <= '0;
                addr_q[i] <= '0;
            end
        end else if (csr_we) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (csr_addr == CSR_PMPCFG_BASE + 12'(i / 4) && !cfg_q[i].l)
                    cfg_q[i] <= pmpcfg_legalize(csr_wdata[8*(i%4) +: 8]);
                if (csr_addr == CSR_PMPADDR_BASE + 12'(i) && !addr_lock[i])
                    addr_q[i] <= csr_wdata[AW-1:0];
            end
        end
    end

    always_comb begin
        csr_rdata = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (csr_addr == CSR_PMPCFG_BASE + 12'(i / 4))
                csr_rdata[8*(i%4) +: 8] = cfg_q[i];
            if (csr_addr == CSR_PMPADDR_BASE + 12'(i))
                csr_rdata = 32'(addr_q[i]);
        end
    end

    logic       hit;
    logic [3:0] hit_idx;
    pmpcfg_t    sel_cfg;
    logic       sel_partial;
    logic       perm_ok;
    logic       fault;

    // Walk from the top down so the lowest-indexed matching entry is the one left selected.
    always_comb begin
        hit         = 1'b0;
        hit_idx     = '0;
        sel_cfg     = '0;
        sel_partial = 1'b0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (ent_match[i]) begin
                hit         = 1'b1;
                hit_idx     = 4'(i);
                sel_cfg     = cfg_q[i];
                sel_partial = ent_partial[i];
            end
        end
    end

    always_comb begin
        case (req_type)
            ACC_READ:  perm_ok = sel_cfg.r;
            ACC_WRITE: perm_ok = sel_cfg.w;
            ACC_EXEC:  perm_ok = sel_cfg.x;
            default:   perm_ok = 1'b0;
        endcase
        if (!hit)
            fault = (req_priv != PRIV_M);
        else if (sel_partial)
            fault = 1'b1;
        else if (req_priv == PRIV_M && !sel_cfg.l)
            fault = 1'b0;
        else
            fault = !perm_ok;
    end

    assign req_ready = !rsp_valid || rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_fault <= 1'b0;
            rsp_hit   <= 1'b0;
            rsp_entry <= '0;
        end else if (req_ready) begin
            rsp_valid <= req_valid;
            if (req_valid) begin
                rsp_fault <= fault;
                rsp_hit   <= hit;
                rsp_entry <= hit_idx;
            end
        end
    end

endmodule
